// File: rtl/dram_catch_arbiter.sv
// dram_catch_arbiter: front end for the layer-1 weight store (DRAM_catch).
// Shares the single RAM read port between two requesters (round-robin),
// passes writes through, and runs a hardware clear that zeroes every word.
// Optional feature macro: DRAM_CATCH_RAW_BYPASS_EN, which forwards same-cycle
// write data to a colliding read so the reader sees the new value.
module dram_catch_arbiter #(
    parameter int D_WIDTH = 4,
    parameter int A_WIDTH = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               r0_req,
    input  logic [A_WIDTH-1:0] r0_addr,
    output logic               r0_gnt,
    input  logic               r1_req,
    input  logic [A_WIDTH-1:0] r1_addr,
    output logic               r1_gnt,
    output logic               rvalid,
    output logic               rid,
    output logic [D_WIDTH-1:0] rdata,
    input  logic               w_req,
    input  logic [A_WIDTH-1:0] w_addr,
    input  logic [D_WIDTH-1:0] w_data,
    output logic               w_gnt,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               mem_rce,
    output logic [A_WIDTH-1:0] mem_ra,
    input  logic [D_WIDTH-1:0] mem_rq,
    output logic               mem_wce,
    output logic [A_WIDTH-1:0] mem_wa,
    output logic [D_WIDTH-1:0] mem_wd
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [A_WIDTH-1:0] PTR_ONE   = {{(A_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic               rr_q, rr_d;
    logic               rvalid_q, rvalid_d;
    logic               rid_q, rid_d;
    logic               clr_done_q, clr_done_d;
    logic               gnt_any;
    logic               gnt_id;

    // Next state, read arbitration and RAM port steering
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        rr_d       = rr_q;
        clr_done_d = 1'b0;
        gnt_any    = 1'b0;
        gnt_id     = 1'b0;
        r0_gnt     = 1'b0;
        r1_gnt     = 1'b0;
        w_gnt      = 1'b0;
        mem_rce    = 1'b0;
        mem_ra     = r0_addr;
        mem_wce    = 1'b0;
        mem_wa     = w_addr;
        mem_wd     = w_data;
        if (state_q == ST_RUN) begin
            clr_ptr_d = '0;
            if (r0_req && r1_req) begin
                gnt_any = 1'b1;
                gnt_id  = rr_q;
            end else if (r0_req) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (r1_req) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
            r0_gnt  = gnt_any && !gnt_id;
            r1_gnt  = gnt_any && gnt_id;
            // any grant hands priority to the other requester
            if (gnt_any) rr_d = ~gnt_id;
            mem_rce = gnt_any;
            mem_ra  = gnt_id ? r1_addr : r0_addr;
            w_gnt   = w_req;
            mem_wce = w_req;
            if (clr_start) state_d = ST_CLEAR;
        end else begin
            // clear owns the write port; reads are held off entirely
            mem_wce   = 1'b1;
            mem_wa    = clr_ptr_q;
            mem_wd    = '0;
            clr_ptr_d = clr_ptr_q + PTR_ONE;
            if (clr_ptr_q == LAST_ADDR) begin
                state_d    = ST_RUN;
                clr_done_d = 1'b1;
            end
        end
        rvalid_d = gnt_any;
        rid_d    = gnt_id;
    end

    // Control and read-return state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            clr_ptr_q  <= '0;
            rr_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            rid_q      <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rr_q       <= rr_d;
            rvalid_q   <= rvalid_d;
            rid_q      <= rid_d;
            clr_done_q <= clr_done_d;
        end
    end

`ifdef DRAM_CATCH_RAW_BYPASS_EN
    logic               hit_q, hit_d;
    logic [D_WIDTH-1:0] byp_q, byp_d;

    // Detect a read colliding with a granted write to the same word
    always_comb begin
        hit_d = gnt_any && w_gnt && (mem_ra == w_addr);
        byp_d = w_data;
    end

    // Hold the collision flag and the forwarded write data for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
            byp_q <= '0;
        end else begin
            hit_q <= hit_d;
            byp_q <= byp_d;
        end
    end

    // rdata is held at zero outside valid beats so reset shows a clean bus
    always_comb begin
        rdata = '0;
        if (rvalid_q) rdata = hit_q ? byp_q : mem_rq;
    end
`else
    // rdata is held at zero outside valid beats so reset shows a clean bus
    always_comb begin
        rdata = '0;
        if (rvalid_q) rdata = mem_rq;
    end
`endif

    assign rvalid   = rvalid_q;
    assign rid      = rid_q;
    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_dram_catch_arbiter.sv
// Bench for dram_catch_arbiter: RAM model, per-cycle reference model, and
// directed scenarios with hand-computed expectations.
module tb_dram_catch_arbiter;
    localparam int AW    = 15;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef DRAM_CATCH_RAW_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_req = 1'b0, r1_req = 1'b0, w_req = 1'b0, clr_start = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0, w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic          r0_gnt, r1_gnt, w_gnt, rvalid, rid, clr_busy, clr_done;
    logic [DW-1:0] rdata;
    logic          mem_rce, mem_wce;
    logic [AW-1:0] mem_ra, mem_wa;
    logic [DW-1:0] mem_rq, mem_wd;

    int tests = 0;
    int fails = 0;

    dram_catch_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt),
        .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_rce(mem_rce), .mem_ra(mem_ra), .mem_rq(mem_rq),
        .mem_wce(mem_wce), .mem_wa(mem_wa), .mem_wd(mem_wd)
    );

    always #5 clk = ~clk;

    // power-up content of the RAM: nonzero garbage so the clear is visible
    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 7 + 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM: 1-cycle registered read, read-before-write on collision
    logic [DW-1:0] ram   [DEPTH];
    bit            ram_w [DEPTH];
    always @(posedge clk) begin
        if (mem_rce) mem_rq <= ram_w[mem_ra] ? ram[mem_ra] : pat(int'(mem_ra));
        if (mem_wce) begin
            ram[mem_wa]   <= mem_wd;
            ram_w[mem_wa] <= 1'b1;
        end
    end

    // Reference model, checked every cycle on the falling edge
    logic [DW-1:0] shadow [DEPTH];
    bit            m_clear, m_rr, m_done, p_vld, p_id;
    int            m_ptr;
    logic [DW-1:0] p_data;
    initial begin
        bit            gany, gid, ew, ewce;
        logic [AW-1:0] era, ewa;
        logic [DW-1:0] ewd;
        for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_clear = 0; m_ptr = 0; m_rr = 0; m_done = 0; p_vld = 0; p_id = 0; p_data = '0;
                chk("rst_rvalid", 32'(rvalid), 32'h0);
                chk("rst_rid", 32'(rid), 32'h0);
                chk("rst_rdata", 32'(rdata), 32'h0);
                chk("rst_busy", 32'(clr_busy), 32'h0);
                chk("rst_done", 32'(clr_done), 32'h0);
            end else begin
                chk("m_rvalid", 32'(rvalid), 32'(p_vld));
                if (p_vld) begin
                    chk("m_rid", 32'(rid), 32'(p_id));
                    chk("m_rdata", 32'(rdata), 32'(p_data));
                end
                chk("m_busy", 32'(clr_busy), 32'(m_clear));
                chk("m_done", 32'(clr_done), 32'(m_done));
                gany = 0; gid = 0;
                if (!m_clear) begin
                    if (r0_req && r1_req) begin gany = 1; gid = m_rr; end
                    else if (r0_req || r1_req) begin gany = 1; gid = r1_req; end
                end
                ew   = !m_clear && w_req;
                ewce = m_clear || ew;
                ewa  = m_clear ? m_ptr[AW-1:0] : w_addr;
                ewd  = m_clear ? '0 : w_data;
                era  = gid ? r1_addr : r0_addr;
                chk("m_r0gnt", 32'(r0_gnt), 32'(gany && !gid));
                chk("m_r1gnt", 32'(r1_gnt), 32'(gany && gid));
                chk("m_wgnt", 32'(w_gnt), 32'(ew));
                chk("m_rce", 32'(mem_rce), 32'(gany));
                if (gany) chk("m_ra", 32'(mem_ra), 32'(era));
                chk("m_wce", 32'(mem_wce), 32'(ewce));
                if (ewce) begin
                    chk("m_wa", 32'(mem_wa), 32'(ewa));
                    chk("m_wd", 32'(mem_wd), 32'(ewd));
                end
                // what the coming rising edge must produce
                p_vld = gany;
                p_id  = gid;
                if (gany) p_data = (BYP && ew && w_addr == era) ? w_data : shadow[era];
                if (ewce) shadow[ewa] = ewd;
                m_done = m_clear && (m_ptr == DEPTH - 1);
                if (gany) m_rr = !gid;
                if (m_clear) begin
                    if (m_ptr == DEPTH - 1) begin m_clear = 0; m_ptr = 0; end
                    else m_ptr++;
                end else if (clr_start) begin
                    m_clear = 1; m_ptr = 0;
                end
            end
        end
    end

    task automatic idle();
        r0_req = 0; r1_req = 0; w_req = 0; clr_start = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 0;
        idle();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Directed scenarios
    initial begin
        bit exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int busy_cnt, done_cnt;
        bit got;
        idle();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_busy", 32'(clr_busy), 32'h0);
        chk("post_rst_rvalid", 32'(rvalid), 32'h0);

        // write 0xA to 5, then read it back on requester 0
        nxt(); w_req = 1; w_addr = 15'h0005; w_data = 4'hA;
        @(negedge clk); chk("t1_wgnt", 32'(w_gnt), 32'h1);
        nxt(); idle(); r0_req = 1; r0_addr = 15'h0005;
        @(negedge clk); chk("t1_r0gnt", 32'(r0_gnt), 32'h1);
        nxt(); idle();
        @(negedge clk);
        chk("t1_rvalid", 32'(rvalid), 32'h1);
        chk("t1_rid", 32'(rid), 32'h0);
        chk("t1_rdata", 32'(rdata), 32'hA);

        // both requesters held from reset: grants alternate 0,1,0,1
        do_reset();
        nxt(); r0_req = 1; r1_req = 1; r0_addr = 15'h0010; r1_addr = 15'h0020;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_r0gnt", 32'(r0_gnt), 32'(!exp_g[k]));
            chk("t2_r1gnt", 32'(r1_gnt), 32'(exp_g[k]));
            if (k > 0) chk("t2_rid", 32'(rid), 32'(exp_g[k-1]));
            nxt();
        end
        idle();
        @(negedge clk);
        chk("t2_rid_last", 32'(rid), 32'h1);
        chk("t2_rvalid_last", 32'(rvalid), 32'h1);

        // full clear with a read and a write parked on it
        nxt(); idle(); clr_start = 1;
        @(negedge clk); chk("t3_busy_pre", 32'(clr_busy), 32'h0);
        nxt(); clr_start = 0;
        r1_req = 1; r1_addr = 15'h7FFF; w_req = 1; w_addr = 15'h0100; w_data = 4'h9;
        busy_cnt = 0; done_cnt = 0; got = 0;
        for (int n = 0; n < 40000 && !got; n++) begin
            @(negedge clk);
            if (n == 0) chk("t3_wa_first", 32'(mem_wa), 32'h0);
            if (n == 32767) chk("t3_wa_last", 32'(mem_wa), 32'h7FFF);
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                got = 1;
                chk("t4_r1gnt_done", 32'(r1_gnt), 32'h1);
                chk("t4_wgnt_done", 32'(w_gnt), 32'h1);
            end else if (n == 100) begin
                chk("t4_r1gnt_clr", 32'(r1_gnt), 32'h0);
                chk("t4_wgnt_clr", 32'(w_gnt), 32'h0);
            end
            if (!got) nxt();
        end
        chk("t3_done_seen", 32'(got), 32'h1);
        nxt(); idle();
        @(negedge clk);
        chk("t3_rvalid", 32'(rvalid), 32'h1);
        chk("t3_rid", 32'(rid), 32'h1);
        chk("t3_rdata_7fff", 32'(rdata), 32'h0);
        chk("t3_done_once", 32'(clr_done), 32'h0);
        chk("t3_busy_cycles", 32'(busy_cnt), 32'd32768);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        // same-cycle write 0x3 and read of 0x0100 (old value 0x9)
        nxt(); idle(); r0_req = 1; r0_addr = 15'h0100; w_req = 1; w_addr = 15'h0100; w_data = 4'h3;
        @(negedge clk);
        chk("t5_r0gnt", 32'(r0_gnt), 32'h1);
        chk("t5_wgnt", 32'(w_gnt), 32'h1);
        nxt(); idle(); r0_req = 1; r0_addr = 15'h0100;
        @(negedge clk);
        chk("t5_raw_rdata", 32'(rdata), BYP ? 32'h3 : 32'h9);
        nxt(); idle();
        @(negedge clk);
        chk("t5_after_rdata", 32'(rdata), 32'h3);

        // reset in the middle of a clear, then restart it
        nxt(); idle(); clr_start = 1;
        nxt(); clr_start = 0;
        got = 0;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge clk);
            if (mem_wa == 15'h01FF) got = 1;
        end
        chk("t6_reach_1ff", 32'(got), 32'h1);
        @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        chk("t6_busy_rst", 32'(clr_busy), 32'h0);
        chk("t6_wce_rst", 32'(mem_wce), 32'h0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_done", 32'(clr_done), 32'h0);
            chk("t6_no_busy", 32'(clr_busy), 32'h0);
        end
        nxt(); r0_req = 1; r0_addr = 15'h0003;
        @(negedge clk); chk("t6_run_gnt", 32'(r0_gnt), 32'h1);
        nxt(); idle(); clr_start = 1;
        nxt(); clr_start = 0;
        @(negedge clk);
        chk("t6_restart_wa0", 32'(mem_wa), 32'h0);
        chk("t6_restart_busy", 32'(clr_busy), 32'h1);
        nxt();
        @(negedge clk);
        chk("t6_restart_wa1", 32'(mem_wa), 32'h1);
        do_reset();
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the whole run is far shorter than this
    initial begin
        #5000000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
